pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_elastic.sv | 95 +++++++++
 tb/tb_pipe_stage_elastic.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared rv64I pipeline types: stage-register payload layout and elastic stage occupancy.
package pipe_pkg;

  localparam int PC_W          = 64;
  localparam int INSTR_W       = 32;
  localparam int COMMIT_INFO_W = 161;

  typedef logic [COMMIT_INFO_W-1:0] commit_info_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    commit_info_t       commit_info;
  } regD_payload_t;

  localparam int REGD_W = $bits(regD_payload_t);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main entry plus skid entry under valid/ready, with
// legacy stall/flush so hazard logic connects to it like a plain stage register.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W       = REGD_W,
  parameter logic [DATA_W-1:0] RESET_VAL    = '0,
  parameter bit                ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  occ_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              in_ready_q, in_ready_d;
  logic              main_v, push, pop;

  assign main_v = (state_q != ST_EMPTY);
  assign push   = in_valid & in_ready_q;
  assign pop    = main_v & out_ready & ~stall;

  always_comb begin
    state_d  = state_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_d_d = RESET_VAL;
      skid_d_d = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d_d = in_data;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d_d = in_data;
          end else if (push) begin
            skid_d_d = in_data;
            state_d  = ST_TWO;
          end else if (pop) begin
            // Bubble carries RESET_VAL, matching legacy NOP insertion.
            if (ZERO_INVALID) main_d_d = RESET_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d_d = skid_d_q;
            skid_d_d = RESET_VAL;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from next state: no path from out_ready/stall.
  assign in_ready_d = (state_d != ST_TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_d_q   <= RESET_VAL;
      skid_d_q   <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_d_q   <= main_d_d;
      skid_d_q   <= skid_d_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_data  = (ZERO_INVALID && !main_v) ? RESET_VAL : main_d_q;
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed vector table plus hand sequences for the elastic stage register.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  logic          clk = 1'b0;
  logic          rst, flush, stall, in_valid, out_ready;
  logic          in_ready, out_valid;
  regD_payload_t in_data, out_data;
  logic [1:0]    occ;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occ      (occ)
  );

  typedef struct {
    logic          rst, flush, stall, iv, ordy;
    regD_payload_t din;
    logic          e_ov, e_ir;
    regD_payload_t e_od;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t tv[$];

  function automatic regD_payload_t mk(input logic [63:0] pc, input logic [31:0] ins);
    regD_payload_t p;
    p       = '0;
    p.pc    = pc;
    p.instr = ins;
    return p;
  endfunction

  // inputs: rst flush stall in_valid out_ready din_pc ; expected after edge: ov ir od_pc occ
  function automatic void addv(input logic r, f, s, iv, ordy, input logic [63:0] dpc,
                               input logic eov, eir, input logic [63:0] epc, input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.iv = iv; v.ordy = ordy;
    v.din = mk(dpc, 32'h0);
    v.e_ov = eov; v.e_ir = eir; v.e_od = mk(epc, 32'h0); v.e_occ = eocc;
    tv.push_back(v);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic chk_d(input string nm, input regD_payload_t act, input regD_payload_t exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_o(input string nm, input logic [1:0] act, input logic [1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic r, f, s, iv, ordy, input regD_payload_t d);
    rst = r; flush = f; stall = s; in_valid = iv; out_ready = ordy; in_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    regD_payload_t zi;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    //     r f s iv or din        ov ir od      occ
    addv(1,0,0,0,0, 64'h0,     0,1, 64'h0,    0); // reset
    addv(1,0,0,0,0, 64'h0,     0,1, 64'h0,    0);
    addv(0,0,0,0,0, 64'h0,     0,1, 64'h0,    0); // idle
    addv(0,0,0,1,1, 64'h1000,  1,1, 64'h1000, 1); // streaming
    addv(0,0,0,1,1, 64'h1004,  1,1, 64'h1004, 1);
    addv(0,0,0,1,1, 64'h1008,  1,1, 64'h1008, 1);
    addv(0,0,0,0,1, 64'h0,     0,1, 64'h0,    0);
    addv(0,0,0,1,0, 64'h10,    1,1, 64'h10,   1); // backpressure
    addv(0,0,0,1,0, 64'h14,    1,0, 64'h10,   2);
    addv(0,0,0,1,0, 64'h18,    1,0, 64'h10,   2); // C held
    addv(0,0,0,1,1, 64'h18,    1,1, 64'h14,   1); // pop A, no push
    addv(0,0,0,1,1, 64'h18,    1,1, 64'h18,   1); // C lands
    addv(0,0,0,0,1, 64'h0,     0,1, 64'h0,    0);
    addv(0,0,0,1,1, 64'h20,    1,1, 64'h20,   1); // stall
    addv(0,0,1,1,1, 64'h24,    1,0, 64'h20,   2);
    addv(0,0,1,0,1, 64'h0,     1,0, 64'h20,   2);
    addv(0,0,0,0,1, 64'h0,     1,1, 64'h24,   1);
    addv(0,0,0,0,1, 64'h0,     0,1, 64'h0,    0);
    addv(0,0,0,1,0, 64'h30,    1,1, 64'h30,   1); // flush in TWO
    addv(0,0,0,1,0, 64'h34,    1,0, 64'h30,   2);
    addv(0,1,0,1,0, 64'h38,    0,1, 64'h0,    0);
    addv(0,0,0,1,0, 64'h40,    1,1, 64'h40,   1); // flush with real push
    addv(0,1,0,1,0, 64'h44,    0,1, 64'h0,    0);
    addv(0,0,0,0,1, 64'h0,     0,1, 64'h0,    0);
    addv(0,0,0,1,0, 64'h50,    1,1, 64'h50,   1); // rst mid-stream
    addv(0,0,0,1,0, 64'h54,    1,0, 64'h50,   2);
    addv(1,0,0,1,1, 64'h58,    0,1, 64'h0,    0);
    addv(0,0,0,0,1, 64'h0,     0,1, 64'h0,    0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].flush, tv[i].stall, tv[i].iv, tv[i].ordy, tv[i].din);
      step();
      chk1 ($sformatf("vec%0d out_valid", i), out_valid, tv[i].e_ov);
      chk1 ($sformatf("vec%0d in_ready",  i), in_ready,  tv[i].e_ir);
      chk_d($sformatf("vec%0d out_data",  i), out_data,  tv[i].e_od);
      chk_o($sformatf("vec%0d occ",       i), occ,       tv[i].e_occ);
    end

    // Bubble after a lone NOP pops must read all-zero.
    zi = mk(64'h0, 32'h00000013);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, zi);
    step();
    chk_d("zi_held", out_data, zi);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk_d("zi_bubble", out_data, '0);
    chk1 ("zi_valid", out_valid, 1'b0);

    // Sustained one-per-cycle throughput.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(64'h2000 + 64'(4 * k), 32'h0));
      step();
      chk_d($sformatf("tput%0d data", k), out_data, mk(64'h2000 + 64'(4 * k), 32'h0));
      chk_o($sformatf("tput%0d occ", k), occ, 2'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    chk_o("tput_drain occ", occ, 2'd0);

    // in_ready must not follow out_ready/stall combinationally.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(64'h60, 32'h0));
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(64'h64, 32'h0));
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    #1;
    chk1("comb in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("reg in_ready", in_ready, 1'b1);
    chk_d("skid to main", out_data, mk(64'h64, 32'h0));
    step();
    chk1("final empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
